// File: rtl/write_command_arbiter.sv
// Round-robin write-command arbiter with free-list tag allocation and PSL command-credit tracking.
// Optional per-requester accept counters on stat_issued when WRITE_ARB_STATS_EN is defined.
//
// state | meaning
// INIT  | loading tags 0..NUM_TAGS-1 into the free list, one per cycle
// RUN   | arbitrating and issuing commands
// DRAIN | no grants; waiting for outstanding tags to return
// STOP  | drained, nothing outstanding (idle)
module write_command_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_TAGS = 32,
  parameter int CREDITS  = 16,
  parameter int DATA_W   = 512
) (
  input  logic                       clock,
  input  logic                       rstn,
  input  logic                       enabled_in,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*64-1:0]      req_address,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_0,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_1,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       cmd_valid,
  output logic [7:0]                 cmd_tag,
  output logic [63:0]                cmd_address,
  output logic [DATA_W-1:0]          write_data_0,
  output logic [DATA_W-1:0]          write_data_1,
  input  logic                       rsp_valid,
  input  logic [7:0]                 rsp_tag,
  input  logic                       credit_return,
  output logic [8:0]                 outstanding,
  output logic                       idle,
`ifdef WRITE_ARB_STATS_EN
  output logic [NUM_REQ*32-1:0]      stat_issued,
`endif
  output logic                       tag_error
);

  localparam int TAG_W = $clog2(NUM_TAGS);
  localparam int RR_W  = $clog2(NUM_REQ);
  localparam int CNT_W = TAG_W + 1;
  localparam logic [8:0] CREDITS_MAX = 9'(CREDITS);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN, S_STOP} state_t;

  state_t             state, state_nxt;
  logic [TAG_W-1:0]   init_cnt;
  logic [TAG_W-1:0]   free_mem [NUM_TAGS];
  logic [TAG_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   free_cnt;
  logic [8:0]         credits;
  logic [NUM_TAGS-1:0] in_flight;
  logic [RR_W-1:0]    rr_ptr;

  logic               can_grant, found, accept;
  logic [RR_W-1:0]    grant_idx;
  logic [RR_W:0]      scan_sum;
  logic [NUM_REQ-1:0] grant_vec;
  logic [63:0]        sel_address;
  logic [DATA_W-1:0]  sel_data_0, sel_data_1;
  logic [TAG_W-1:0]   pop_tag, rsp_idx, push_tag;
  logic               rsp_ok, push_en;
  logic [8:0]         outstanding_nxt;

  assign can_grant = (state == S_RUN) && (free_cnt != '0) && (credits != '0);

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_vec = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_sum  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr} + (RR_W+1)'(i);
      if (scan_sum >= (RR_W+1)'(NUM_REQ)) scan_sum = scan_sum - (RR_W+1)'(NUM_REQ);
      if (!found && req_valid[scan_sum[RR_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = scan_sum[RR_W-1:0];
      end
    end
    if (found) grant_vec[grant_idx] = 1'b1;
  end

  assign accept    = can_grant && found;
  assign req_ready = accept ? grant_vec : '0;

  always_comb begin
    sel_address = '0;
    sel_data_0  = '0;
    sel_data_1  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vec[i]) begin
        sel_address = sel_address | req_address[i*64 +: 64];
        sel_data_0  = sel_data_0 | req_data_0[i*DATA_W +: DATA_W];
        sel_data_1  = sel_data_1 | req_data_1[i*DATA_W +: DATA_W];
      end
    end
  end

  // Tags outside the pool can never be in flight and are reported as errors.
  assign rsp_idx  = rsp_tag[TAG_W-1:0];
  assign rsp_ok   = rsp_valid && ({1'b0, rsp_tag} < 9'(NUM_TAGS)) && in_flight[rsp_idx];
  assign pop_tag  = free_mem[rd_ptr];
  assign push_en  = (state == S_INIT) || rsp_ok;
  assign push_tag = (state == S_INIT) ? init_cnt : rsp_idx;

  assign outstanding_nxt = outstanding + 9'(accept) - 9'(rsp_ok);
  assign idle            = (state == S_STOP);

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (init_cnt == TAG_W'(NUM_TAGS - 1)) state_nxt = S_RUN;
      S_RUN:   if (!enabled_in) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (enabled_in)                 state_nxt = S_RUN;
        else if (outstanding_nxt == '0) state_nxt = S_STOP;
      end
      S_STOP:  if (enabled_in) state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) state <= S_INIT;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (push_en) free_mem[wr_ptr] <= push_tag;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      init_cnt     <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      free_cnt     <= '0;
      credits      <= CREDITS_MAX;
      in_flight    <= '0;
      rr_ptr       <= '0;
      outstanding  <= '0;
      tag_error    <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_tag      <= '0;
      cmd_address  <= '0;
      write_data_0 <= '0;
      write_data_1 <= '0;
    end else begin
      if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (accept)  rd_ptr <= rd_ptr + 1'b1;
      free_cnt    <= free_cnt + CNT_W'(push_en) - CNT_W'(accept);
      outstanding <= outstanding_nxt;

      if (accept && !credit_return)
        credits <= credits - 1'b1;
      else if (!accept && credit_return && (credits != CREDITS_MAX))
        credits <= credits + 1'b1;

      if (accept) in_flight[pop_tag] <= 1'b1;
      if (rsp_ok) in_flight[rsp_idx] <= 1'b0;
      if (rsp_valid && !rsp_ok) tag_error <= 1'b1;

      if (accept)
        rr_ptr <= (grant_idx == RR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

      cmd_valid <= accept;
      if (accept) begin
        cmd_tag      <= 8'(pop_tag);
        cmd_address  <= sel_address;
        write_data_0 <= sel_data_0;
        write_data_1 <= sel_data_1;
      end
    end
  end

`ifdef WRITE_ARB_STATS_EN
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      stat_issued <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && grant_vec[i])
          stat_issued[i*32 +: 32] <= stat_issued[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule
